fen_pos_stream: RTL and testbench
=================================

# fen_pos_stream

Parses the board field of an ASCII FEN string, one byte per cycle, and emits the 64-square piece stream consumed by the move-generator board lookup stage (`in_pos_valid` / `in_pos_data` / `in_pos_sop`). It expands digit run-lengths into empty squares, validates rank and file structure, captures side-to-move, then discards the rest of the FEN record. It sits between the host byte interface and the movegen lookup stage.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  FEN byte present
- `in_data`  in  8  ASCII FEN byte
- `in_last`  in  1  final byte of the FEN record
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `out_pos_valid`  out  1  one square per asserted cycle; no backpressure
- `out_pos_data`  out  4  piece code of the square
- `out_pos_sop`  out  1  high with square 0 (a8) only
- `out_stm`  out  1  side to move: 1 = white, 0 = black; held until next record
- `out_done`  out  1  single-cycle pulse when the record's `in_last` byte is accepted
- `out_err`  out  1  valid with `out_done`; held until the next record's first byte

## Operation
- Reset values: all outputs 0 except `in_ready` = 1. State BOARD; all counters 0.
- Piece code: 0 = empty; bits[2:0]: P=1, N=2, B=3, R=4, Q=5, K=6; bit3 = black (lowercase).
- Square order is FEN order a8..h8, a7..h7, …, h1. A 7-bit `sq` counter runs 0..64, a 4-bit `file` counter 0..8, and a 3-bit `rank` counter.
- States:
  - **BOARD**:
    - Letter: emit one square, `file`+1.
    - Digit `1`–`8`: emit n empties. The first empty is emitted now; the remaining n-1 go to the `run` counter.
    - `/`: requires `file==8` and `rank<7`; clears `file` and increments `rank`.
    - Space: requires `sq==64`; moves to STM.
  - **EXPAND**: while `run>0`, emit one empty per cycle, hold `in_ready`=0, and decrement `run`. Return to BOARD when `run` reaches 0.
  - **STM**: `w` sets `out_stm`=1, `b` sets it to 0; then go to SKIP. Any other byte is an error.
  - **SKIP**: consume bytes until `in_last`.
- Errors, any of:
  - illegal character, including `0` and `9`;
  - `file` would exceed 8;
  - `/` with `file`≠8;
  - more than 8 ranks;
  - space with `sq`≠64.

  On an error, set the sticky `err` and go to SKIP. No further squares are emitted. Squares already emitted stand, and downstream discards them on `out_err`.
- `in_last` accepted in any state: pulse `out_done`, present `out_err`, return to BOARD, clear counters. If `in_last` arrives before STM has completed, that is an error.
- The first byte of a new record clears `out_err`.

## Timing
- Outputs are registered. A byte accepted at edge k produces its first square at edge k (visible in cycle k+1).
- Digit n gives n consecutive `out_pos_valid` cycles. `in_ready` is low for the n-1 cycles after acceptance.
- `in_ready` depends only on state/`run`, never combinationally on `in_valid`.
- `in_valid` gaps are allowed anywhere; output gaps mirror input gaps.
- `out_pos_sop` is asserted exactly when `sq==0` is emitted.
- `out_done` / `out_err` are registered one edge after `in_last` is accepted.
- Async reset mid-record or mid-EXPAND: everything returns to reset values immediately. The partial stream is abandoned, with no `out_done`.
- Best case is one square per cycle, so the full board takes 64 cycles plus 7 `/` bytes.

## Structure
- `chess_pkg` holds:
  - the piece-code constants (`PIECE_EMPTY`, `PIECE_PAWN`…`PIECE_KING`, `PIECE_BLACK` bit);
  - the ASCII constants for `/`, space, `w`, `b`;
  - the state enum `fen_state_t`.
- One combinational sub-module, `fen_char_decode`: takes an ASCII byte and returns `is_piece`, `piece[3:0]`, `is_digit`, `digit[3:0]`, `is_slash`, `is_space`.

## Test plan
- **Start position** `rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1`:
  - 64 squares; first is 0xC with sop; square 4 is 0xE; squares 16–47 are 0; square 60 is 0x6.
  - `out_stm`=1; `out_done` with `out_err`=0.
- **Empty board** `8/8/8/8/8/8/8/8 b - - 0 1`:
  - 64 zeros with `in_ready` low 7 cycles after each `8`.
  - `out_stm`=0; `out_err`=0.
- **Malformed**:
  - `9/…` gives `out_err`=1 with no squares emitted.
  - `7/…` errors on `/` after 7 squares.
  - `rnbqkbnrr/…` errors on the 9th letter.
  - In every case `out_done` arrives at `in_last`.
- **Random `in_valid` gaps** on the start position: the square sequence and sop are identical to the gap-free run, and there is no emission while `in_valid`=0.
- **Reset mid-EXPAND** (assert `rst_n`=0 during the `8` run of rank 6):
  - Outputs go to 0 immediately; there is no `out_done`.
  - A following full start-position record streams correctly from sop.
- **Back-to-back records**: `out_err` from a bad record clears on the first byte of a good record, which completes with `out_err`=0.

Source files
------------

// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared piece codes, FEN ASCII constants and parser state enum
package chess_pkg;

  localparam logic [3:0] PIECE_EMPTY  = 4'd0;
  localparam logic [3:0] PIECE_PAWN   = 4'd1;
  localparam logic [3:0] PIECE_KNIGHT = 4'd2;
  localparam logic [3:0] PIECE_BISHOP = 4'd3;
  localparam logic [3:0] PIECE_ROOK   = 4'd4;
  localparam logic [3:0] PIECE_QUEEN  = 4'd5;
  localparam logic [3:0] PIECE_KING   = 4'd6;
  localparam logic [3:0] PIECE_BLACK  = 4'd8;

  localparam logic [7:0] ASCII_SLASH  = 8'h2F;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_W      = 8'h77;
  localparam logic [7:0] ASCII_B      = 8'h62;

  typedef enum logic [1:0] {
    ST_BOARD  = 2'd0,
    ST_EXPAND = 2'd1,
    ST_STM    = 2'd2,
    ST_SKIP   = 2'd3
  } fen_state_t;

endpackage

// File: rtl/fen_char_decode.sv
// rtl/fen_char_decode.sv - classifies one FEN board byte
module fen_char_decode
  import chess_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_piece,
  output logic [3:0] piece,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_slash,
  output logic       is_space
);

  // Map piece letters to codes; uppercase is white, lowercase sets the black bit
  always_comb begin
    is_piece = 1'b1;
    piece    = PIECE_EMPTY;
    case (ch)
      8'h50: piece = PIECE_PAWN;
      8'h4E: piece = PIECE_KNIGHT;
      8'h42: piece = PIECE_BISHOP;
      8'h52: piece = PIECE_ROOK;
      8'h51: piece = PIECE_QUEEN;
      8'h4B: piece = PIECE_KING;
      8'h70: piece = PIECE_BLACK | PIECE_PAWN;
      8'h6E: piece = PIECE_BLACK | PIECE_KNIGHT;
      8'h62: piece = PIECE_BLACK | PIECE_BISHOP;
      8'h72: piece = PIECE_BLACK | PIECE_ROOK;
      8'h71: piece = PIECE_BLACK | PIECE_QUEEN;
      8'h6B: piece = PIECE_BLACK | PIECE_KING;
      default: begin
        is_piece = 1'b0;
        piece    = PIECE_EMPTY;
      end
    endcase
  end

  // Only '1'..'8' are run lengths; '0' and '9' fall through as illegal
  assign is_digit = (ch >= 8'h31) && (ch <= 8'h38);
  assign digit    = is_digit ? ch[3:0] : 4'd0;
  assign is_slash = (ch == ASCII_SLASH);
  assign is_space = (ch == ASCII_SPACE);

endmodule

// File: rtl/fen_pos_stream.sv
// rtl/fen_pos_stream.sv - FEN board field parser emitting the 64-square piece stream
module fen_pos_stream
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_pos_valid,
  output logic [3:0] out_pos_data,
  output logic       out_pos_sop,
  output logic       out_stm,
  output logic       out_done,
  output logic       out_err
);

  fen_state_t state_q, state_d;
  logic [6:0] sq_q, sq_d;
  logic [3:0] file_q, file_d;
  logic [2:0] rank_q, rank_d;
  logic [2:0] run_q, run_d;
  logic       err_q, err_d;
  logic       rec_start_q, rec_start_d;

  logic       pos_valid_d;
  logic [3:0] pos_data_d;
  logic       pos_sop_d;
  logic       stm_d;
  logic       done_d;
  logic       err_out_d;

  logic       dec_is_piece;
  logic [3:0] dec_piece;
  logic       dec_is_digit;
  logic [3:0] dec_digit;
  logic       dec_is_slash;
  logic       dec_is_space;

  logic       accept;
  logic       emit;
  logic [3:0] emit_code;
  logic       bad;
  logic [4:0] file_sum;

  fen_char_decode u_decode (
    .ch       (in_data),
    .is_piece (dec_is_piece),
    .piece    (dec_piece),
    .is_digit (dec_is_digit),
    .digit    (dec_digit),
    .is_slash (dec_is_slash),
    .is_space (dec_is_space)
  );

  // Byte intake stalls only while a digit run is being expanded
  assign in_ready = (state_q != ST_EXPAND);
  assign accept   = in_valid && in_ready;
  assign file_sum = {1'b0, file_q} + {1'b0, dec_digit};

  // Next-state, counter and output decisions for one cycle
  always_comb begin
    state_d     = state_q;
    sq_d        = sq_q;
    file_d      = file_q;
    rank_d      = rank_q;
    run_d       = run_q;
    err_d       = err_q;
    rec_start_d = rec_start_q;
    stm_d       = out_stm;
    err_out_d   = out_err;
    done_d      = 1'b0;
    emit        = 1'b0;
    emit_code   = PIECE_EMPTY;
    bad         = 1'b0;

    if (state_q == ST_EXPAND) begin
      emit  = 1'b1;
      run_d = run_q - 3'd1;
      if (run_q == 3'd1) begin
        state_d = ST_BOARD;
      end
    end else if (accept) begin
      if (rec_start_q) begin
        rec_start_d = 1'b0;
        err_out_d   = 1'b0;
      end
      case (state_q)
        ST_BOARD: begin
          if (dec_is_piece) begin
            if (file_q == 4'd8) begin
              bad = 1'b1;
            end else begin
              emit      = 1'b1;
              emit_code = dec_piece;
              file_d    = file_q + 4'd1;
            end
          end else if (dec_is_digit) begin
            if (file_sum > 5'd8) begin
              bad = 1'b1;
            end else begin
              emit   = 1'b1;
              file_d = file_sum[3:0];
              run_d  = 3'(dec_digit - 4'd1);
              if (dec_digit != 4'd1) begin
                state_d = ST_EXPAND;
              end
            end
          end else if (dec_is_slash) begin
            if ((file_q != 4'd8) || (rank_q == 3'd7)) begin
              bad = 1'b1;
            end else begin
              file_d = 4'd0;
              rank_d = rank_q + 3'd1;
            end
          end else if (dec_is_space) begin
            if (sq_q != 7'd64) begin
              bad = 1'b1;
            end else begin
              state_d = ST_STM;
            end
          end else begin
            bad = 1'b1;
          end
        end
        ST_STM: begin
          if (in_data == ASCII_W) begin
            stm_d   = 1'b1;
            state_d = ST_SKIP;
          end else if (in_data == ASCII_B) begin
            stm_d   = 1'b0;
            state_d = ST_SKIP;
          end else begin
            bad = 1'b1;
          end
        end
        default: begin
        end
      endcase

      if (bad) begin
        err_d   = 1'b1;
        state_d = ST_SKIP;
      end

      // A record that ends inside the board field is malformed; its final byte emits nothing
      if (in_last) begin
        emit        = 1'b0;
        done_d      = 1'b1;
        err_out_d   = err_q | bad | (state_q == ST_BOARD);
        err_d       = 1'b0;
        rec_start_d = 1'b1;
        state_d     = ST_BOARD;
        file_d      = 4'd0;
        rank_d      = 3'd0;
        run_d       = 3'd0;
        sq_d        = 7'd0;
      end
    end

    if (emit) begin
      sq_d = sq_q + 7'd1;
    end
    pos_valid_d = emit;
    pos_data_d  = emit_code;
    pos_sop_d   = emit && (sq_q == 7'd0);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOARD;
      sq_q          <= 7'd0;
      file_q        <= 4'd0;
      rank_q        <= 3'd0;
      run_q         <= 3'd0;
      err_q         <= 1'b0;
      rec_start_q   <= 1'b1;
      out_pos_valid <= 1'b0;
      out_pos_data  <= PIECE_EMPTY;
      out_pos_sop   <= 1'b0;
      out_stm       <= 1'b0;
      out_done      <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sq_q          <= sq_d;
      file_q        <= file_d;
      rank_q        <= rank_d;
      run_q         <= run_d;
      err_q         <= err_d;
      rec_start_q   <= rec_start_d;
      out_pos_valid <= pos_valid_d;
      out_pos_data  <= pos_data_d;
      out_pos_sop   <= pos_sop_d;
      out_stm       <= stm_d;
      out_done      <= done_d;
      out_err       <= err_out_d;
    end
  end

endmodule

// File: tb/tb_fen_pos_stream.sv
// tb/tb_fen_pos_stream.sv - self-checking bench for fen_pos_stream
module tb_fen_pos_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_pos_valid;
  logic [3:0] out_pos_data;
  logic       out_pos_sop;
  logic       out_stm;
  logic       out_done;
  logic       out_err;

  int checks = 0;
  int errors = 0;

  int   got_sq[$];
  int   got_sop[$];
  int   low_runs[$];
  int   low_run = 0;
  int   done_cnt = 0;
  logic done_err = 1'b0;

  int exp_q[$];
  bit m_err = 1'b0;
  bit m_stm = 1'b0;

  typedef struct packed {
    logic [7:0] gap_pct;
    logic       exp_err;
    logic       exp_stm;
    logic [7:0] nsq;
    logic [7:0] probe_idx;
    logic [3:0] probe_val;
  } vec_t;

  localparam int NVEC = 12;
  vec_t  vec [NVEC];
  string fens [NVEC];

  fen_pos_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_pos_valid (out_pos_valid),
    .out_pos_data  (out_pos_data),
    .out_pos_sop   (out_pos_sop),
    .out_stm       (out_stm),
    .out_done      (out_done),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_pos_valid) begin
      got_sq.push_back(int'(out_pos_data));
      got_sop.push_back(int'(out_pos_sop));
    end
    if (out_done) begin
      done_cnt++;
      done_err = out_err;
    end
    if (!in_ready) begin
      low_run++;
    end else if (low_run > 0) begin
      low_runs.push_back(low_run);
      low_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic int piece_of(input byte c);
    string up = "PNBRQK";
    string lo = "pnbrqk";
    for (int j = 0; j < 6; j++) begin
      if (c == up.getc(j)) return j + 1;
      if (c == lo.getc(j)) return j + 9;
    end
    return -1;
  endfunction

  function automatic int sq_at(input int idx);
    if (idx < got_sq.size()) return got_sq[idx];
    return -1;
  endfunction

  // Reference: walk the record by FEN rules, build the square list, error flag and side to move
  task automatic model_record(input string s);
    int  f = 0;
    int  r = 0;
    int  phase = 0;
    int  p;
    int  k;
    bit  bad = 1'b0;
    byte c;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (phase == 0) begin
        if (i == s.len() - 1) begin
          bad = 1'b1;
        end else begin
          p = piece_of(c);
          if (p >= 0) begin
            if (f >= 8) bad = 1'b1;
            else begin exp_q.push_back(p); f++; end
          end else if (c >= 8'h31 && c <= 8'h38) begin
            k = int'(c) - 48;
            if (f + k > 8) bad = 1'b1;
            else begin
              for (int j = 0; j < k; j++) exp_q.push_back(0);
              f += k;
            end
          end else if (c == 8'h2F) begin
            if (f != 8 || r >= 7) bad = 1'b1;
            else begin f = 0; r++; end
          end else if (c == 8'h20) begin
            if (exp_q.size() != 64) bad = 1'b1;
            else phase = 1;
          end else begin
            bad = 1'b1;
          end
        end
        if (bad) phase = 2;
      end else if (phase == 1) begin
        if (c == 8'h77) m_stm = 1'b1;
        else if (c == 8'h62) m_stm = 1'b0;
        else bad = 1'b1;
        phase = 2;
      end
    end
    m_err = bad;
  endtask

  task automatic drive_byte(input byte c, input bit last);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = c;
    in_last  = last;
    while (!in_ready && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drive_ready_bound", budget < 20, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_record(input string s, input int gap_pct);
    int d0;
    int mm;
    int nsop;
    int n;
    bit sop_ok;
    check("err_held_before_record", out_err, m_err);
    model_record(s);
    got_sq.delete();
    got_sop.delete();
    low_runs.delete();
    d0 = done_cnt;
    for (int i = 0; i < s.len(); i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      drive_byte(s.getc(i), i == s.len() - 1);
      if (i == 0) check("err_clear_first_byte", out_err, 0);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("done_pulses", done_cnt - d0, 1);
    check("model_err", done_err, m_err);
    check("model_stm", out_stm, m_stm);
    check("model_nsq", got_sq.size(), exp_q.size());
    mm = -1;
    n = (got_sq.size() > exp_q.size()) ? got_sq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (mm < 0 && (i >= got_sq.size() || i >= exp_q.size() || got_sq[i] != exp_q[i])) mm = i;
    end
    check("model_first_diff_idx", mm, -1);
    nsop = 0;
    foreach (got_sop[i]) nsop += got_sop[i];
    if (exp_q.size() == 0) sop_ok = (nsop == 0);
    else sop_ok = (nsop == 1) && (got_sop.size() > 0) && (got_sop[0] == 1);
    check("sop_only_on_sq0", sop_ok, 1);
  endtask

  initial begin
    string start_fen;
    string s;
    int    zeros;
    int    d0;

    start_fen = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1";
    fens[0]  = start_fen;
    vec[0]   = '{8'd0,  1'b0, 1'b1, 8'd64, 8'd4,   4'hE};
    fens[1]  = "8/8/8/8/8/8/8/8 b - - 0 1";
    vec[1]   = '{8'd0,  1'b0, 1'b0, 8'd64, 8'd63,  4'h0};
    fens[2]  = "9/8/8/8/8/8/8/8 w - - 0 1";
    vec[2]   = '{8'd0,  1'b1, 1'b0, 8'd0,  8'hFF,  4'h0};
    fens[3]  = "7/8/8/8/8/8/8/8 w - - 0 1";
    vec[3]   = '{8'd0,  1'b1, 1'b0, 8'd7,  8'd6,   4'h0};
    fens[4]  = "rnbqkbnrr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1";
    vec[4]   = '{8'd0,  1'b1, 1'b0, 8'd8,  8'd7,   4'hC};
    fens[5]  = start_fen;
    vec[5]   = '{8'd40, 1'b0, 1'b1, 8'd64, 8'd60,  4'h6};
    fens[6]  = "rnbqkbnr/pppp9/8/8/8/8/PPPPPPPP/RNBQKBNR b - - 0 1";
    vec[6]   = '{8'd0,  1'b1, 1'b1, 8'd12, 8'd11,  4'h9};
    fens[7]  = start_fen;
    vec[7]   = '{8'd0,  1'b0, 1'b1, 8'd64, 8'd0,   4'hC};
    fens[8]  = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBN w - - 0 1";
    vec[8]   = '{8'd0,  1'b1, 1'b1, 8'd63, 8'd62,  4'h2};
    fens[9]  = "8/8/8/8/8/8/8/8/8 w - - 0 1";
    vec[9]   = '{8'd0,  1'b1, 1'b1, 8'd64, 8'd0,   4'h0};
    fens[10] = "4k3/8/8/8/8/8/8/4K3 b - - 0 1";
    vec[10]  = '{8'd20, 1'b0, 1'b0, 8'd64, 8'd4,   4'hE};
    fens[11] = "08/8/8/8/8/8/8/8 w - - 0 1";
    vec[11]  = '{8'd0,  1'b1, 1'b0, 8'd0,  8'hFF,  4'h0};

    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_pos_valid", out_pos_valid, 0);
    check("reset_pos_data", out_pos_data, 0);
    check("reset_sop", out_pos_sop, 0);
    check("reset_stm", out_stm, 0);
    check("reset_done", out_done, 0);
    check("reset_err", out_err, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      run_record(fens[i], int'(vec[i].gap_pct));
      check($sformatf("v%0d_nsq", i), got_sq.size(), vec[i].nsq);
      check($sformatf("v%0d_err", i), done_err, vec[i].exp_err);
      check($sformatf("v%0d_stm", i), out_stm, vec[i].exp_stm);
      if (vec[i].probe_idx != 8'hFF)
        check($sformatf("v%0d_probe_sq%0d", i, vec[i].probe_idx),
              sq_at(int'(vec[i].probe_idx)), vec[i].probe_val);
      if (i == 0) begin
        check("start_sq0", sq_at(0), 12);
        check("start_sq60", sq_at(60), 6);
        zeros = 0;
        for (int j = 16; j < 48; j++) if (sq_at(j) == 0) zeros++;
        check("start_zeros_16_47", zeros, 32);
      end
      if (i == 1) begin
        check("empty_ready_low_runs", low_runs.size(), 8);
        foreach (low_runs[j]) check($sformatf("empty_ready_low_len%0d", j), low_runs[j], 7);
      end
    end

    // Random boards, gaps and occasional corruption
    for (int t = 0; t < 20; t++) begin
      string pcs;
      int f;
      int k;
      pcs = "PNBRQKpnbrqk";
      s = "";
      for (int r = 0; r < 8; r++) begin
        f = 0;
        while (f < 8) begin
          if ($urandom_range(1) == 1) begin
            k = $urandom_range(1, 8 - f);
            s = $sformatf("%s%0d", s, k);
            f += k;
          end else begin
            s = $sformatf("%s%c", s, pcs.getc($urandom_range(11)));
            f++;
          end
        end
        if (r < 7) s = {s, "/"};
      end
      if ($urandom_range(1) == 1) s = {s, " w - - 0 1"};
      else s = {s, " b - - 0 1"};
      if ($urandom_range(3) == 0) s.putc($urandom_range(s.len() - 2), byte'($urandom_range(32, 126)));
      run_record(s, $urandom_range(50));
    end

    // Reset during the rank-6 run: stream abandoned, no done, next record restarts cleanly
    run_record(start_fen, 0);
    d0 = done_cnt;
    s = "rnbqkbnr/pppppppp/8";
    for (int i = 0; i < s.len(); i++) drive_byte(s.getc(i), 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_pos_valid", out_pos_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_stm", out_stm, 0);
    check("midrst_done", out_done, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt - d0, 0);
    m_stm = 1'b0;
    m_err = 1'b0;
    run_record(start_fen, 0);
    check("after_rst_sq0", sq_at(0), 12);
    check("after_rst_nsq", got_sq.size(), 64);
    check("after_rst_err", done_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
